serial_carry_seq: RTL
=====================

// Module: serial_carry_seq
// PURPOSE
//  Bit-serial add/subtract sequencer built around one ADDER_CARRY-style cell plus a carry flop.
//  Accepts a WIDTH-bit operand pair over a valid/ready handshake and processes one bit per enabled clock, LSB first.
//  Returns sum, carry-out and signed overflow over a second valid/ready handshake.
//  Trades latency for area in genesis3 fabric where a full carry chain is not wanted.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..64
//  CNT_W  $clog2(WIDTH+1)  bit-counter width; derived, do not override
// PORTS
//  C          in   1      clock, rising edge
//  R          in   1      reset; asynchronous, active-high
//  E          in   1      clock enable; 0 freezes all state, outputs hold
//  in_valid   in   1      operand request valid
//  in_ready   out  1      sequencer can accept operands
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_sub     in   1      1 = A-B, 0 = A+B
//  in_cin     in   1      carry-in for add; ignored when in_sub=1
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_sum    out  WIDTH  result, modulo 2^WIDTH
//  out_cout   out  1      carry-out of MSB (sub: 1 = no borrow)
//  out_ovf    out  1      signed overflow = carry into MSB XOR carry out of MSB
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (R=1, async): state=IDLE; in_ready=1; out_valid=0; out_sum=0; out_cout=0; out_ovf=0; busy=0; carry flop=0; counter=0.
//  State changes and register loads happen only on a rising C edge with E=1. R overrides E.
//  IDLE: in_ready=1. When in_valid=1:
//   - Latch A into shift register a_sh.
//   - Latch b_sh = in_sub ? ~in_b : in_b.
//   - Set carry = in_sub ? 1 : in_cin; counter=0; go to RUN.
//  RUN: in_ready=0. Each enabled cycle:
//   - p = a_sh[0]^b_sh[0]; g = a_sh[0]&b_sh[0].
//   - Sum bit = p^carry, shifted into out_sum from the MSB side.
//   - carry <= p ? carry : g.
//   - a_sh and b_sh shift right by 1; counter++.
//   - On the bit with counter==WIDTH-1, also capture c_msb_in=carry (before update) for ovf.
//   - After the WIDTH-th bit: out_cout=final carry; out_ovf=c_msb_in^final carry; go to DONE.
//  DONE: out_valid=1; out_sum, out_cout and out_ovf stable.
//   - out_valid && out_ready && E -> IDLE, out_valid=0.
//   - Results hold in out_* until the next RUN overwrites them.
//  Latency: handshake edge T0; out_valid visible after edge T0+WIDTH (WIDTH enabled edges in RUN). Throughput: 1 op per WIDTH+2 cycles.
//  No accept in DONE, even with simultaneous out_ready: in_ready stays 0 until IDLE (next cycle).
//  E=0 at any point: no state, counter, carry or shift advance; handshakes are not consumed.
//  R asserted mid-RUN or in DONE: operation aborted; no out_valid is ever produced for it.
//  in_* are sampled only at the accept edge; later changes have no effect.
// TESTING
//  WIDTH=8, E=1: A=0x0F, B=0x01, add, cin=0 -> out_valid 8 cycles after accept; sum=0x10, cout=0, ovf=0.
//  A=0xFF, B=0x01, add -> sum=0x00, cout=1, ovf=0. A=0x7F, B=0x01, add -> sum=0x80, cout=0, ovf=1.
//  A=0x05, B=0x07, sub -> sum=0xFE, cout=0, ovf=0. A=0x80, B=0x01, sub -> sum=0x7F, cout=1, ovf=1.
//  E low for 3 cycles mid-RUN -> latency grows by exactly 3; same result. out_ready held 0 for 5 cycles -> out_valid and sum stable; in_ready=0 throughout.
//  R pulsed at RUN bit 4 -> all outputs at reset values; next op 0x01+0x01 -> 0x02 with normal latency.
//  Random back-to-back ops (1000) vs reference model {cout,sum}=A+B+cin (sub: A+~B+1); check ovf and in_ready timing.

Source files
------------

// File: rtl/serial_carry_seq.sv
// Bit-serial add/subtract sequencer: one full-adder cell plus a carry flop,
// processing one operand bit per enabled clock, LSB first.
module serial_carry_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             C,
  input  logic             R,
  input  logic             E,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising C edge where E=1 and both
  // valid and ready are high; valid never depends combinationally on ready.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic w_accept;
  logic w_run;
  logic w_last;
  logic w_p;
  logic w_g;
  logic w_s;
  logic w_c_nxt;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_run    = (r_state == ST_RUN);
  assign w_last   = w_run && (r_cnt == CNT_W'(WIDTH - 1));

  // Single adder cell: propagate selects the incoming carry, else generate.
  assign w_p     = r_a_sh[0] ^ r_b_sh[0];
  assign w_g     = r_a_sh[0] & r_b_sh[0];
  assign w_s     = w_p ^ r_carry;
  assign w_c_nxt = w_p ? r_carry : w_g;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_state <= ST_IDLE;
    end else if (E) begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (E) begin
      if (w_accept) begin
        r_a_sh  <= in_a;
        r_b_sh  <= in_sub ? ~in_b : in_b;
        r_carry <= in_sub ? 1'b1 : in_cin;
        r_cnt   <= '0;
      end else if (w_run) begin
        r_sum   <= {w_s, r_sum[WIDTH-1:1]};
        r_carry <= w_c_nxt;
        r_a_sh  <= r_a_sh >> 1;
        r_b_sh  <= r_b_sh >> 1;
        r_cnt   <= r_cnt + CNT_W'(1);
        // r_carry here is still the carry into the MSB.
        if (w_last) begin
          r_cout <= w_c_nxt;
          r_ovf  <= r_carry ^ w_c_nxt;
        end
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;
  assign dbg_state = r_state;

endmodule
